// File: rtl/arb_mux_pkg.sv
// Shared constants for the arbitrated multiplexer: the arbitration mode encodings.
package arb_mux_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
endpackage

// File: rtl/arb_mux_if.sv
// Channel-side and output-side handshake bundle for arb_mux.
// The master modport is the traffic source/sink; the slave modport is the mux.
interface arb_mux_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/arb_mux_rr_arbiter.sv
// One-hot grant generator: fixed lowest-index priority or round-robin search
// starting at ptr and wrapping from N-1 back to 0.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = MODE_RR,
  localparam int SW  = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic [SW:0] start;
  logic [SW:0] idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    start = (MODE == MODE_RR) ? {1'b0, ptr} : '0;
    // One extra index bit keeps start+k from overflowing before the mod-N fold.
    for (int k = 0; k < N; k++) begin
      idx = start + (SW+1)'(k);
      if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
      if (!found && req[idx[SW-1:0]]) begin
        grant[idx[SW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrated multiplexer with a single registered output stage that
// refills in the same edge it drains, giving one word per cycle.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int MODE = MODE_RR
) (
  input logic       clk,
  input logic       rst_n,
  arb_mux_if.slave  bus
);
  localparam int SW = $clog2(N);

  logic [N-1:0]  grant;
  logic [SW-1:0] ptr;
  logic [SW-1:0] g;
  logic [W-1:0]  sel_data;
  logic          load;
  logic          take;
  logic          out_valid_r;
  logic [W-1:0]  out_data_r;
  logic [SW-1:0] out_sel_r;

  rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
    .req   (bus.in_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign load = !out_valid_r || bus.out_ready;
  assign take = load && (|bus.in_valid);

  // rst_n gates in_ready because the empty register would otherwise look ready.
  assign bus.in_ready = grant & {N{load & rst_n}};

  always_comb begin
    g        = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        g        = SW'(i);
        sel_data = bus.in_data[i*W +: W];
      end
    end
  end

  // Output stage: drains and refills in one edge; ptr advances only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      ptr         <= '0;
    end else begin
      if (load) out_valid_r <= |bus.in_valid;
      if (take) begin
        out_data_r <= sel_data;
        out_sel_r  <= g;
        if (MODE == MODE_RR) ptr <= (g == SW'(N-1)) ? '0 : g + SW'(1);
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;
endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench: three arb_mux configurations (N=4 RR, N=4 fixed, N=3 RR)
// driven in lockstep and compared every cycle against a transaction-level model.
module tb_arb_mux;
  import arb_mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arb_mux_if #(.W(8), .N(4)) bi_rr ();
  arb_mux_if #(.W(8), .N(4)) bi_fx ();
  arb_mux_if #(.W(8), .N(3)) bi_n3 ();

  arb_mux #(.W(8), .N(4), .MODE(MODE_RR))    u_rr (.clk(clk), .rst_n(rst_n), .bus(bi_rr.slave));
  arb_mux #(.W(8), .N(4), .MODE(MODE_FIXED)) u_fx (.clk(clk), .rst_n(rst_n), .bus(bi_fx.slave));
  arb_mux #(.W(8), .N(3), .MODE(MODE_RR))    u_n3 (.clk(clk), .rst_n(rst_n), .bus(bi_n3.slave));

  int checks = 0;
  int errors = 0;

  int nch[3]   = '{4, 4, 3};
  int mmode[3] = '{MODE_RR, MODE_FIXED, MODE_RR};

  // Model state: register contents and round-robin pointer per instance.
  int m_v[3], m_d[3], m_s[3], m_p[3];
  int vld[3];
  int dat[3][4];
  int ordy;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int vm, input int n, input int start);
    for (int j = 0; j < n; j++) begin
      int c;
      c = (start + j) % n;
      if (((vm >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic drive();
    bi_rr.in_valid  = 4'(vld[0]);
    bi_fx.in_valid  = 4'(vld[1]);
    bi_n3.in_valid  = 3'(vld[2]);
    bi_rr.in_data   = {8'(dat[0][3]), 8'(dat[0][2]), 8'(dat[0][1]), 8'(dat[0][0])};
    bi_fx.in_data   = {8'(dat[1][3]), 8'(dat[1][2]), 8'(dat[1][1]), 8'(dat[1][0])};
    bi_n3.in_data   = {8'(dat[2][2]), 8'(dat[2][1]), 8'(dat[2][0])};
    bi_rr.out_ready = ordy[0];
    bi_fx.out_ready = ordy[0];
    bi_n3.out_ready = ordy[0];
  endtask

  task automatic sample(output int o_r[3], output int o_v[3], output int o_d[3],
                        output int o_s[3], output int o_p[3]);
    o_r[0] = int'(bi_rr.in_ready);  o_r[1] = int'(bi_fx.in_ready);  o_r[2] = int'(bi_n3.in_ready);
    o_v[0] = int'(bi_rr.out_valid); o_v[1] = int'(bi_fx.out_valid); o_v[2] = int'(bi_n3.out_valid);
    o_d[0] = int'(bi_rr.out_data);  o_d[1] = int'(bi_fx.out_data);  o_d[2] = int'(bi_n3.out_data);
    o_s[0] = int'(bi_rr.out_sel);   o_s[1] = int'(bi_fx.out_sel);   o_s[2] = int'(bi_n3.out_sel);
    o_p[0] = int'(u_rr.ptr);        o_p[1] = int'(u_fx.ptr);        o_p[2] = int'(u_n3.ptr);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 0; m_d[k] = 0; m_s[k] = 0; m_p[k] = 0;
    end
  endtask

  // Everything must read zero while reset is held, even with requests pending.
  task automatic rst_chk();
    int o_r[3], o_v[3], o_d[3], o_s[3], o_p[3];
    sample(o_r, o_v, o_d, o_s, o_p);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rdy%0d", k), o_r[k], 0);
      chk($sformatf("rst_vld%0d", k), o_v[k], 0);
      chk($sformatf("rst_dat%0d", k), o_d[k], 0);
      chk($sformatf("rst_sel%0d", k), o_s[k], 0);
      chk($sformatf("rst_ptr%0d", k), o_p[k], 0);
    end
  endtask

  // Called just after a rising edge: drive, check mid-cycle, advance model at the edge.
  task automatic cyc();
    int o_r[3], o_v[3], o_d[3], o_s[3], o_p[3];
    int n_v[3], n_d[3], n_s[3], n_p[3];
    drive();
    @(negedge clk);
    sample(o_r, o_v, o_d, o_s, o_p);
    for (int k = 0; k < 3; k++) begin
      int vm, g, ld, er;
      vm = vld[k] & ((1 << nch[k]) - 1);
      g  = pick(vm, nch[k], (mmode[k] == MODE_RR) ? m_p[k] : 0);
      ld = (m_v[k] == 0 || ordy != 0) ? 1 : 0;
      er = (ld != 0 && g >= 0) ? (1 << g) : 0;
      chk($sformatf("rdy%0d", k), o_r[k], er);
      chk($sformatf("vld%0d", k), o_v[k], m_v[k]);
      chk($sformatf("dat%0d", k), o_d[k], m_d[k]);
      chk($sformatf("sel%0d", k), o_s[k], m_s[k]);
      if (mmode[k] == MODE_RR) chk($sformatf("ptr%0d", k), o_p[k], m_p[k]);
      n_v[k] = m_v[k]; n_d[k] = m_d[k]; n_s[k] = m_s[k]; n_p[k] = m_p[k];
      if (ld != 0) begin
        n_v[k] = (g >= 0) ? 1 : 0;
        if (g >= 0) begin
          n_d[k] = dat[k][g];
          n_s[k] = g;
          if (mmode[k] == MODE_RR) n_p[k] = (g + 1) % nch[k];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      m_v[k] = n_v[k]; m_d[k] = n_d[k]; m_s[k] = n_s[k]; m_p[k] = n_p[k];
    end
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < 3; k++) vld[k] = v;
  endtask

  task automatic ramp_data();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) dat[k][i] = 'hA0 + i;
  endtask

  initial begin
    rst_n = 1'b0;
    ordy  = 1;
    model_reset();
    set_all('hF);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) dat[k][i] = int'($urandom_range(0, 255));
    drive();
    #12;
    rst_chk();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All channels requesting with ramp data: rotation 0,1,2,3,0 on the RR instance.
    ramp_data();
    set_all('hF);
    repeat (6) cyc();

    // Channels 1 and 3 requesting: fixed priority always picks channel 1.
    set_all('hA);
    repeat (5) cyc();

    // Output stall for three cycles after a capture, then release.
    set_all('hF);
    ordy = 1;
    cyc();
    ordy = 0;
    repeat (3) cyc();
    ordy = 1;
    repeat (4) cyc();

    // Channels 0 and 2: the N=3 instance alternates 0,2 with ptr wrapping to 0.
    set_all('h5);
    repeat (6) cyc();

    // A single one-cycle request on channel 2, then idle.
    set_all('h4);
    cyc();
    set_all(0);
    repeat (3) cyc();

    // Random traffic with random backpressure.
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 3; k++) begin
        vld[k] = int'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) dat[k][i] = int'($urandom_range(0, 255));
      end
      ordy = ($urandom_range(0, 3) != 0) ? 1 : 0;
      cyc();
    end

    // Reset asserted mid-cycle while the register holds a word.
    set_all('hF);
    ordy = 0;
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    rst_chk();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_all('h6);
    ordy = 1;
    repeat (3) cyc();
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 3; k++) vld[k] = int'($urandom_range(0, 15));
      ordy = int'($urandom_range(0, 1));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
